serial_adder: RTL



---
 rtl/serial_adder.sv | 115 +++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell walks the operands LSB first, one bit per clock,
// and the finished word plus final carry are published together on a one-cycle done pulse.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             last_bit;
  logic             load;
  logic             bit_s;
  logic             bit_c;

  assign last_bit = (cnt_q == CntW'(WIDTH - 1));
  // Start is only honoured outside ADD; DONE reloads for back-to-back adds.
  assign load     = start && (state_q != StAdd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StAdd;
      StAdd:   if (last_bit) state_d = StDone;
      StDone:  state_d = start ? StAdd : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StAdd);
    done = (state_q == StDone);
  end

  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    bit_s   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    bit_c   = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    if (load) begin
      a_sh_d  = a;
      b_sh_d  = b;
      carry_d = carry_in;
      cnt_d   = '0;
      psum_d  = '0;
    end else if (state_q == StAdd) begin
      a_sh_d            = a_sh_q >> 1;
      b_sh_d            = b_sh_q >> 1;
      psum_d            = psum_q >> 1;
      psum_d[WIDTH-1]   = bit_s;
      carry_d           = bit_c;
      cnt_d             = cnt_q + CntW'(1);
      if (last_bit) begin
        sum_d  = psum_d;
        cout_d = bit_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule
